// File: rtl/ram_pkg.sv
// Shared memory-port definitions: width encodings, RAM FSM states and the
// byte-lane extract/merge helpers reused by the memory blocks.
package ram_pkg;

  typedef enum logic [1:0] {
    MEM_B    = 2'd0,
    MEM_H    = 2'd1,
    MEM_W    = 2'd2,
    MEM_RSVD = 2'd3
  } mem_width_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ram_state_e;

  // Pick the addressed lane out of a word and zero- or sign-extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  width,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (width)
      MEM_B:   return {{24{sext & b[7]}}, b};
      MEM_H:   return {{16{sext & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  width);
    logic [31:0] r;
    r = old_word;
    case (width)
      MEM_B: r[{lane, 3'b000} +: 8] = wdata[7:0];
      MEM_H: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      MEM_W:   r = wdata;
      default: r = old_word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_lat_if.sv
// Load/store memory port between a core (master) and a RAM (slave).
interface ram_lat_if;
  logic [31:0] mem_addr;
  logic        mem_read_valid;
  logic        mem_write_valid;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_width;
  logic        mem_signed;
  logic        mem_busy;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        mem_error;

  modport master (
    output mem_addr, mem_read_valid, mem_write_valid, mem_write_data,
           mem_width, mem_signed,
    input  mem_busy, mem_read_data, mem_ready, mem_error
  );

  modport slave (
    input  mem_addr, mem_read_valid, mem_write_valid, mem_write_data,
           mem_width, mem_signed,
    output mem_busy, mem_read_data, mem_ready, mem_error
  );
endinterface

// File: rtl/ram_lat.sv
// Word RAM with configurable depth/latency and B/H/W lane access.
// Define RAM_ALIGN_CHECK_EN to fault misaligned H/W accesses.
module ram_lat
  import ram_pkg::*;
#(
  parameter int unsigned SIZE      = 32'h1000,
  parameter int unsigned LATENCY   = 1,
  parameter              INIT_FILE = ""
) (
  input  logic      clk,
  input  logic      rst_n,
  ram_lat_if.slave  mem_bus
);

  localparam int unsigned AW       = $clog2(SIZE);
  localparam logic [3:0]  CNT_LAST = 4'(LATENCY - 1);

  logic [31:0] mem_array [SIZE];

  ram_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  width_q;
  logic        signed_q;
  logic        is_read_q;
  logic        is_write_q;
  logic        ready_q;
  logic        error_q;
  logic [31:0] rdata_q;

  logic [AW-1:0] idx;
  logic [31:0]   old_word;
  logic [31:0]   wr_word_d;
  logic          range_fault;
  logic          align_fault;
  logic          fault;
  logic          last;
  logic          commit_we;

  assign idx         = addr_q[AW+1:2];
  assign old_word    = mem_array[idx];
  assign range_fault = ({32'd0, addr_q} >= (64'(SIZE) << 2));

`ifdef RAM_ALIGN_CHECK_EN
  assign align_fault = ((width_q == MEM_H) && addr_q[0]) ||
                       ((width_q == MEM_W) && (addr_q[1:0] != 2'b00));
`else
  assign align_fault = 1'b0;
`endif

  assign fault     = range_fault || (width_q == MEM_RSVD) || align_fault;
  assign last      = (state_q == WAIT) && (cnt_q == CNT_LAST);
  assign commit_we = last && is_write_q && !fault;
  assign wr_word_d = lane_merge(old_word, wdata_q, addr_q[1:0], width_q);

  // Array has no reset so it maps onto RAM; an asserted rst_n drops state_q
  // to IDLE, which suppresses any uncommitted write.
  always_ff @(posedge clk) begin
    if (commit_we) mem_array[idx] <= wr_word_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      width_q    <= '0;
      signed_q   <= 1'b0;
      is_read_q  <= 1'b0;
      is_write_q <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_bus.mem_read_valid || mem_bus.mem_write_valid) begin
            addr_q     <= mem_bus.mem_addr;
            wdata_q    <= mem_bus.mem_write_data;
            width_q    <= mem_bus.mem_width;
            signed_q   <= mem_bus.mem_signed;
            is_read_q  <= mem_bus.mem_read_valid;
            is_write_q <= mem_bus.mem_write_valid;
            cnt_q      <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            error_q <= fault;
            // A read alongside a write reports the pre-write word.
            if (fault)          rdata_q <= '0;
            else if (is_read_q) rdata_q <= lane_extract(old_word, addr_q[1:0],
                                                        width_q, signed_q);
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_bus.mem_busy      = (state_q == WAIT);
  assign mem_bus.mem_ready     = ready_q;
  assign mem_bus.mem_error     = error_q;
  assign mem_bus.mem_read_data = rdata_q;

endmodule

// File: tb/tb_ram_lat.sv
// Scoreboard bench for ram_lat (SIZE=64 words, LATENCY=3); honours
// RAM_ALIGN_CHECK_EN when choosing expected alignment behaviour.
module tb_ram_lat;
  import ram_pkg::*;

  localparam int unsigned SIZE = 64;
  localparam int unsigned LAT  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_lat_if bus ();

  ram_lat #(.SIZE(SIZE), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] exp_d;
    logic        exp_e;
  } req_t;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rdata = '0;
  int          errors = 0;
  int          checks = 0;

  // A plain write leaves the read data register untouched, so its expected
  // value is whatever the previous completion reported.
  task automatic issue(input req_t r);
    exp_t x;
    @(negedge clk);
    bus.mem_addr        = r.addr;
    bus.mem_read_valid  = r.rd;
    bus.mem_write_valid = r.wr;
    bus.mem_write_data  = r.wdata;
    bus.mem_width       = r.width;
    bus.mem_signed      = r.sgn;
    @(posedge clk);
    #1;
    bus.mem_read_valid  = 1'b0;
    bus.mem_write_valid = 1'b0;
    x.name = r.name;
    x.e    = r.exp_e;
    x.d    = (r.wr && !r.rd && !r.exp_e) ? last_rdata : r.exp_d;
    last_rdata = x.d;
    sb.push_back(x);
  endtask

  task automatic collect(output int cyc, output int busy_n, output logic [31:0] d,
                         output logic e, output bit tmo);
    cyc = 0; busy_n = 0; tmo = 1'b0; d = '0; e = 1'b0;
    while (!bus.mem_ready) begin
      if (bus.mem_busy) busy_n++;
      if (cyc >= 20) begin tmo = 1'b1; break; end
      @(posedge clk);
      #1;
      cyc++;
    end
    d = bus.mem_read_data;
    e = bus.mem_error;
  endtask

  task automatic test_reset();
    bus.mem_addr = '0; bus.mem_read_valid = 1'b0; bus.mem_write_valid = 1'b0;
    bus.mem_write_data = '0; bus.mem_width = MEM_W; bus.mem_signed = 1'b0;
    #12;
    checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b want 0", bus.mem_busy); end
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset ready: got %b want 0", bus.mem_ready); end
    checks++; if (bus.mem_error !== 1'b0) begin errors++; $display("[TB] FAIL reset error: got %b want 0", bus.mem_error); end
    checks++; if (bus.mem_read_data !== 32'h0) begin errors++; $display("[TB] FAIL reset rdata: got %h want 0", bus.mem_read_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    req_t t[$];
    exp_t x;
    int cyc, bn; logic [31:0] d; logic e; bit tmo;
    t.push_back('{"wr W 10", 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, MEM_W, 1'b0, 32'h0, 1'b0});
    t.push_back('{"rd W 10", 32'h10, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'hDEADBEEF, 1'b0});
    foreach (t[i]) begin
      issue(t[i]);
      collect(cyc, bn, d, e, tmo);
      x = sb.pop_front();
      checks++; if (tmo || cyc != LAT) begin errors++; $display("[TB] FAIL %s latency: got %0d (timeout=%0b) want %0d", x.name, cyc, tmo, LAT); end
      checks++; if (bn != LAT || bus.mem_busy !== 1'b0) begin errors++; $display("[TB] FAIL %s busy: got %0d busy cycles, busy@ready=%b want %0d,0", x.name, bn, bus.mem_busy, LAT); end
      checks++; if (d !== x.d) begin errors++; $display("[TB] FAIL %s data: got %h want %h", x.name, d, x.d); end
      checks++; if (e !== x.e) begin errors++; $display("[TB] FAIL %s error: got %b want %b", x.name, e, x.e); end
    end
  endtask

  task automatic test_lanes();
    req_t t[$];
    exp_t x;
    int cyc, bn; logic [31:0] d; logic e; bit tmo;
    t.push_back('{"wr W 20",    32'h20, 1'b0, 1'b1, 32'h80FF7F01, MEM_W, 1'b0, 32'h0, 1'b0});
    t.push_back('{"rd Bs 20",   32'h20, 1'b1, 1'b0, 32'h0, MEM_B, 1'b1, 32'h00000001, 1'b0});
    t.push_back('{"rd Bs 21",   32'h21, 1'b1, 1'b0, 32'h0, MEM_B, 1'b1, 32'h0000007F, 1'b0});
    t.push_back('{"rd Bs 22",   32'h22, 1'b1, 1'b0, 32'h0, MEM_B, 1'b1, 32'hFFFFFFFF, 1'b0});
    t.push_back('{"rd Bs 23",   32'h23, 1'b1, 1'b0, 32'h0, MEM_B, 1'b1, 32'hFFFFFF80, 1'b0});
    t.push_back('{"rd Hu 22",   32'h22, 1'b1, 1'b0, 32'h0, MEM_H, 1'b0, 32'h000080FF, 1'b0});
    t.push_back('{"rd Hs 22",   32'h22, 1'b1, 1'b0, 32'h0, MEM_H, 1'b1, 32'hFFFF80FF, 1'b0});
    t.push_back('{"rd Bu 23",   32'h23, 1'b1, 1'b0, 32'h0, MEM_B, 1'b0, 32'h00000080, 1'b0});
    t.push_back('{"rd Hs 20",   32'h20, 1'b1, 1'b0, 32'h0, MEM_H, 1'b1, 32'h00007F01, 1'b0});
    foreach (t[i]) begin
      issue(t[i]);
      collect(cyc, bn, d, e, tmo);
      x = sb.pop_front();
      checks++; if (tmo || cyc != LAT) begin errors++; $display("[TB] FAIL %s latency: got %0d (timeout=%0b) want %0d", x.name, cyc, tmo, LAT); end
      checks++; if (d !== x.d) begin errors++; $display("[TB] FAIL %s data: got %h want %h", x.name, d, x.d); end
      checks++; if (e !== x.e) begin errors++; $display("[TB] FAIL %s error: got %b want %b", x.name, e, x.e); end
    end
  endtask

  task automatic test_merge();
    req_t t[$];
    exp_t x;
    int cyc, bn; logic [31:0] d; logic e; bit tmo;
    t.push_back('{"wr W 20",  32'h20, 1'b0, 1'b1, 32'h11223344, MEM_W, 1'b0, 32'h0, 1'b0});
    t.push_back('{"wr B 22",  32'h22, 1'b0, 1'b1, 32'hFFFFFFAA, MEM_B, 1'b0, 32'h0, 1'b0});
    t.push_back('{"rd W mB",  32'h20, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h11AA3344, 1'b0});
    t.push_back('{"wr H 20",  32'h20, 1'b0, 1'b1, 32'h1234BEEF, MEM_H, 1'b0, 32'h0, 1'b0});
    t.push_back('{"rd W mH",  32'h20, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h11AABEEF, 1'b0});
    t.push_back('{"wr B 23",  32'h23, 1'b0, 1'b1, 32'h00000077, MEM_B, 1'b0, 32'h0, 1'b0});
    t.push_back('{"rd W mB3", 32'h20, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h77AABEEF, 1'b0});
    foreach (t[i]) begin
      issue(t[i]);
      collect(cyc, bn, d, e, tmo);
      x = sb.pop_front();
      checks++; if (tmo || cyc != LAT) begin errors++; $display("[TB] FAIL %s latency: got %0d (timeout=%0b) want %0d", x.name, cyc, tmo, LAT); end
      checks++; if (d !== x.d) begin errors++; $display("[TB] FAIL %s data: got %h want %h", x.name, d, x.d); end
      checks++; if (e !== x.e) begin errors++; $display("[TB] FAIL %s error: got %b want %b", x.name, e, x.e); end
    end
  endtask

  task automatic test_faults();
    req_t t[$];
    exp_t x;
    int cyc, bn; logic [31:0] d; logic e; bit tmo;
    t.push_back('{"wr W 0",     32'h0,   1'b0, 1'b1, 32'hA5A55A5A, MEM_W, 1'b0, 32'h0, 1'b0});
    t.push_back('{"rd W oob",   32'h100, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h0, 1'b1});
    t.push_back('{"wr W oob",   32'h100, 1'b0, 1'b1, 32'hFFFFFFFF, MEM_W, 1'b0, 32'h0, 1'b1});
    t.push_back('{"rd rsvd",    32'h0,   1'b1, 1'b0, 32'h0, MEM_RSVD, 1'b0, 32'h0, 1'b1});
    t.push_back('{"wr rsvd",    32'h0,   1'b0, 1'b1, 32'h0, MEM_RSVD, 1'b0, 32'h0, 1'b1});
    t.push_back('{"rd W top",   32'hFFFFFFFC, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h0, 1'b1});
    t.push_back('{"rd W 0",     32'h0,   1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'hA5A55A5A, 1'b0});
`ifdef RAM_ALIGN_CHECK_EN
    t.push_back('{"align W 2",  32'h2,   1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h0, 1'b1});
    t.push_back('{"align H 1",  32'h1,   1'b1, 1'b0, 32'h0, MEM_H, 1'b0, 32'h0, 1'b1});
`else
    t.push_back('{"align W 2",  32'h2,   1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'hA5A55A5A, 1'b0});
    t.push_back('{"align H 1",  32'h1,   1'b1, 1'b0, 32'h0, MEM_H, 1'b0, 32'h00005A5A, 1'b0});
`endif
    t.push_back('{"rd W 0 b",   32'h0,   1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'hA5A55A5A, 1'b0});
    foreach (t[i]) begin
      issue(t[i]);
      collect(cyc, bn, d, e, tmo);
      x = sb.pop_front();
      checks++; if (tmo || cyc != LAT) begin errors++; $display("[TB] FAIL %s latency: got %0d (timeout=%0b) want %0d", x.name, cyc, tmo, LAT); end
      checks++; if (d !== x.d) begin errors++; $display("[TB] FAIL %s data: got %h want %h", x.name, d, x.d); end
      checks++; if (e !== x.e) begin errors++; $display("[TB] FAIL %s error: got %b want %b", x.name, e, x.e); end
    end
  endtask

  task automatic test_rw_collision();
    req_t t[$];
    exp_t x;
    int cyc, bn; logic [31:0] d; logic e; bit tmo;
    t.push_back('{"wr W 30",    32'h30, 1'b0, 1'b1, 32'h00000001, MEM_W, 1'b0, 32'h0, 1'b0});
    t.push_back('{"rw W 30",    32'h30, 1'b1, 1'b1, 32'h00000002, MEM_W, 1'b0, 32'h00000001, 1'b0});
    t.push_back('{"rd W 30",    32'h30, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h00000002, 1'b0});
    t.push_back('{"rw Bs 31",   32'h31, 1'b1, 1'b1, 32'h000000FF, MEM_B, 1'b1, 32'h00000000, 1'b0});
    t.push_back('{"rd W 30 b",  32'h30, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h0000FF02, 1'b0});
    foreach (t[i]) begin
      issue(t[i]);
      collect(cyc, bn, d, e, tmo);
      x = sb.pop_front();
      checks++; if (tmo || cyc != LAT) begin errors++; $display("[TB] FAIL %s latency: got %0d (timeout=%0b) want %0d", x.name, cyc, tmo, LAT); end
      checks++; if (d !== x.d) begin errors++; $display("[TB] FAIL %s data: got %h want %h", x.name, d, x.d); end
      checks++; if (e !== x.e) begin errors++; $display("[TB] FAIL %s error: got %b want %b", x.name, e, x.e); end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t x;
    int cyc, bn, extra; logic [31:0] d; logic e; bit tmo;
    issue('{"rd busy", 32'h30, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h0000FF02, 1'b0});
    bus.mem_addr = 32'h30; bus.mem_width = MEM_W; bus.mem_write_data = 32'h00000099;
    bus.mem_write_valid = 1'b1; bus.mem_read_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_write_valid = 1'b0; bus.mem_read_valid = 1'b0;
    collect(cyc, bn, d, e, tmo);
    x = sb.pop_front();
    checks++; if (tmo || cyc + 1 != LAT) begin errors++; $display("[TB] FAIL %s latency: got %0d (timeout=%0b) want %0d", x.name, cyc + 1, tmo, LAT); end
    checks++; if (d !== x.d) begin errors++; $display("[TB] FAIL %s data: got %h want %h", x.name, d, x.d); end
    extra = 0;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("[TB] FAIL busy extra ready: got %0d pulses want 0", extra); end
    issue('{"rd after busy", 32'h30, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h0000FF02, 1'b0});
    collect(cyc, bn, d, e, tmo);
    x = sb.pop_front();
    checks++; if (tmo || d !== x.d) begin errors++; $display("[TB] FAIL %s data: got %h (timeout=%0b) want %h", x.name, d, tmo, x.d); end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    int cyc, bn; logic [31:0] d; logic e; bit tmo;
    issue('{"wr W 40", 32'h40, 1'b0, 1'b1, 32'h12345678, MEM_W, 1'b0, 32'h0, 1'b0});
    collect(cyc, bn, d, e, tmo);
    x = sb.pop_front();
    checks++; if (tmo || d !== x.d) begin errors++; $display("[TB] FAIL %s data: got %h (timeout=%0b) want %h", x.name, d, tmo, x.d); end
    issue('{"wr W 40 drop", 32'h40, 1'b0, 1'b1, 32'hFFFF0000, MEM_W, 1'b0, 32'h0, 1'b0});
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset busy: got %b want 0", bus.mem_busy); end
    checks++; if (bus.mem_ready !== 1'b0 || bus.mem_error !== 1'b0) begin errors++; $display("[TB] FAIL midreset ready/error: got %b/%b want 0/0", bus.mem_ready, bus.mem_error); end
    checks++; if (bus.mem_read_data !== 32'h0) begin errors++; $display("[TB] FAIL midreset rdata: got %h want 0", bus.mem_read_data); end
    sb.delete();
    last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue('{"rd W 40", 32'h40, 1'b1, 1'b0, 32'h0, MEM_W, 1'b0, 32'h12345678, 1'b0});
    collect(cyc, bn, d, e, tmo);
    x = sb.pop_front();
    checks++; if (tmo || cyc != LAT) begin errors++; $display("[TB] FAIL %s latency: got %0d (timeout=%0b) want %0d", x.name, cyc, tmo, LAT); end
    checks++; if (d !== x.d) begin errors++; $display("[TB] FAIL %s data: got %h want %h", x.name, d, x.d); end
  endtask

  // Each request is presented in the previous request's ready cycle, so the
  // latency checks throughout also cover back-to-back acceptance.
  initial begin
    test_reset();
    test_latency();
    test_lanes();
    test_merge();
    test_faults();
    test_rw_collision();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
